instr_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the datapath/control pair.
- Owns the program counter and issues reads to a synchronous instruction memory.
- Buffers returned 16-bit instructions in a small prefetch queue and presents them with a valid/ready handshake.
- Redirects (jump/branch taken) restart fetch from a new PC; in-flight and queued instructions are discarded.

---
 rtl/risc_pkg.sv | 15 +
 rtl/instr_fetch_unit_fetch_queue.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared constants and types for the fetch stage: widths, PC step and the fetch FSM state encoding.
package risc_pkg;

  localparam int PC_W     = 16;
  localparam int INSTR_W  = 16;
  localparam int OPCODE_W = 4;
  localparam int PC_STEP  = 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Prefetch FIFO holding {pc, instr} pairs; flush wins over push/pop, push and pop may coincide when full.
module fetch_queue
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [DATA_W-1:0]          head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  import risc_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              doPush;
  logic              doPop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    doPush  = push_i && !flush_i;
    doPop   = pop_i && !flush_i && (count_q != '0);
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      wrPtr_d = wrPtr_q + PTR_W'(doPush);
      rdPtr_d = rdPtr_q + PTR_W'(doPop);
      count_d = count_q + (PTR_W+1)'(doPush) - (PTR_W+1)'(doPop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem read issue, prefetch queue and redirect handling.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module instr_fetch_unit
#(
  parameter int              PC_W     = risc_pkg::PC_W,
  parameter int              INSTR_W  = risc_pkg::INSTR_W,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
)(
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [3:0]         opcode,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
`endif
);

  import risc_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e             state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [PC_W-1:0]          respPc_q, respPc_d;
  logic                     inflight_q, inflight_d;
  logic                     kill_q, kill_d;

  logic [CNT_W-1:0]         qCount;
  logic [PC_W+INSTR_W-1:0]  qHead;
  logic                     qEmpty;
  logic                     qPush;
  logic                     qPop;
  logic [CNT_W:0]           occupancy;
  logic                     credit;
  logic                     issue;
  logic                     respValid;
  logic                     fire;
  logic                     bypassPop;
  logic [PC_W-1:0]          headPc;
  logic [INSTR_W-1:0]       headInstr;

  fetch_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (PC_W + INSTR_W)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (qPush),
    .push_data_i ({respPc_q, imem_rdata}),
    .pop_i       (qPop),
    .flush_i     (redirect_valid),
    .head_o      (qHead),
    .count_o     (qCount)
  );

  // An arriving response is presented directly when the queue is empty, giving one-cycle fetch-to-valid.
  always_comb begin
    respValid   = inflight_q && !kill_q;
    qEmpty      = (qCount == '0);
    instr_valid = !qEmpty || respValid;
    fire        = instr_valid && instr_ready;
    bypassPop   = qEmpty && respValid && fire;
    qPush       = respValid && !bypassPop;
    qPop        = fire && !qEmpty;
    occupancy   = {1'b0, qCount} + (CNT_W+1)'(inflight_q);
    credit      = occupancy < (CNT_W+1)'(DEPTH);
    issue       = (state_q == FETCH) && !halt && !redirect_valid && credit;

    headPc    = qHead[PC_W+INSTR_W-1:INSTR_W];
    headInstr = qHead[INSTR_W-1:0];
    if (qEmpty) begin
      headPc    = respPc_q;
      headInstr = imem_rdata;
    end

    instr     = instr_valid ? headInstr : '0;
    instr_pc  = instr_valid ? headPc : '0;
    opcode    = instr[INSTR_W-1 -: OPCODE_W];
    imem_req  = issue;
    imem_addr = pc_q;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    respPc_d   = respPc_q;
    inflight_d = issue;
    kill_d     = 1'b0;
    if (issue) begin
      pc_d     = pc_q + PC_W'(PC_STEP);
      respPc_d = pc_q;
    end
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH,
      STALL:   state_d = (halt || !credit) ? STALL : FETCH;
      default: state_d = BOOT;
    endcase
    // Redirect overrides everything; the queue flush happens inside the FIFO on the same edge.
    if (redirect_valid) begin
      pc_d   = {redirect_pc[PC_W-1:1], 1'b0};
      kill_d = inflight_q;
      if (state_q != BOOT) begin
        state_d = halt ? STALL : FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      respPc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      respPc_q   <= respPc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0]    perfFetched_q, perfFetched_d;
  logic [31:0]    perfFlushed_q, perfFlushed_d;
  logic [CNT_W:0] dropCount;
  logic [32:0]    flushSum;

  // Entries lost to a redirect are whatever is queued or arriving, minus the one handed over this cycle.
  always_comb begin
    dropCount     = {1'b0, qCount} + (CNT_W+1)'(respValid) - (CNT_W+1)'(fire);
    flushSum      = {1'b0, perfFlushed_q} + 33'(dropCount);
    perfFetched_d = perfFetched_q;
    perfFlushed_d = perfFlushed_q;
    if (fire && (perfFetched_q != '1)) begin
      perfFetched_d = perfFetched_q + 32'd1;
    end
    if (redirect_valid) begin
      perfFlushed_d = flushSum[32] ? '1 : flushSum[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perfFetched_q <= '0;
      perfFlushed_q <= '0;
    end else begin
      perfFetched_q <= perfFetched_d;
      perfFlushed_q <= perfFlushed_d;
    end
  end

  assign perf_fetched = perfFetched_q;
  assign perf_flushed = perfFlushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with a one-cycle-latency instruction memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [3:0]  opcode;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          hlt;
    bit          rv;
    logic [15:0] rpc;
    bit          eReq;
    logic [15:0] eAddr;
    bit          eValid;
    logic [15:0] ePc;
  } vec_t;

  vec_t vecs[$];

  instr_fetch_unit #(
    .PC_W     (16),
    .INSTR_W  (16),
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for the address requested in one cycle appears in the next.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ 16'hA500;
  end

  function automatic vec_t mk(input bit rst, input bit rdy, input bit hlt, input bit rv,
                              input logic [15:0] rpc, input bit eReq, input logic [15:0] eAddr,
                              input bit eValid, input logic [15:0] ePc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.hlt = hlt; v.rv = rv; v.rpc = rpc;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.ePc = ePc;
    return v;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    compare({tag, ".valid"},  32'(instr_valid), 32'd0);
    compare({tag, ".req"},    32'(imem_req),    32'd0);
    compare({tag, ".addr"},   32'(imem_addr),   32'h0000);
    compare({tag, ".instr"},  32'(instr),       32'h0000);
    compare({tag, ".pc"},     32'(instr_pc),    32'h0000);
    compare({tag, ".opcode"}, 32'(opcode),      32'h0);
`ifdef FETCH_PERF_EN
    compare({tag, ".perfFetched"}, perf_fetched, 32'd0);
    compare({tag, ".perfFlushed"}, perf_flushed, 32'd0);
`endif
  endtask

  // Asserts reset at the current time, checks the immediate effect, releases just after an edge.
  task automatic doReset(input int idx);
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    halt = 1'b0;
    #1;
    checkResetState($sformatf("v%0d.reset", idx));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    instr_ready    = v.rdy;
    halt           = v.hlt;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [15:0] expInstr;
    logic [15:0] expPc;
    logic [3:0]  expOp;
    expInstr = v.eValid ? (v.ePc ^ 16'hA500) : 16'h0000;
    expPc    = v.eValid ? v.ePc : 16'h0000;
    expOp    = expInstr[15:12];
    compare($sformatf("v%0d.req", idx),    32'(imem_req),    32'(v.eReq));
    compare($sformatf("v%0d.addr", idx),   32'(imem_addr),   32'(v.eAddr));
    compare($sformatf("v%0d.valid", idx),  32'(instr_valid), 32'(v.eValid));
    compare($sformatf("v%0d.pc", idx),     32'(instr_pc),    32'(expPc));
    compare($sformatf("v%0d.instr", idx),  32'(instr),       32'(expInstr));
    compare($sformatf("v%0d.opcode", idx), 32'(opcode),      32'(expOp));
  endtask

  initial begin
    // Streaming from reset with ready held high.
    vecs.push_back(mk(1,1,0,0,16'h0, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0002, 1,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0004, 1,16'h0002));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0006, 1,16'h0004));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0008, 1,16'h0006));
    // Ready low: four reads fill the queue, head stays at pc 0, then drains and resumes at 8.
    vecs.push_back(mk(1,0,0,0,16'h0, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,16'h0002, 1,16'h0000));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,16'h0004, 1,16'h0000));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,16'h0006, 1,16'h0000));
    for (int k = 0; k < 7; k++) vecs.push_back(mk(0,0,0,0,16'h0, 0,16'h0008, 1,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 0,16'h0008, 1,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 0,16'h0008, 1,16'h0002));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0008, 1,16'h0004));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h000A, 1,16'h0006));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h000C, 1,16'h0008));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h000E, 1,16'h000A));
    // Redirect to an odd target with three queued entries and one read in flight.
    vecs.push_back(mk(1,0,0,0,16'h0, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,16'h0002, 1,16'h0000));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,16'h0004, 1,16'h0000));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,16'h0006, 1,16'h0000));
    vecs.push_back(mk(0,0,0,1,16'h0041, 0,16'h0008, 1,16'h0000));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,16'h0040, 0,16'h0000));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,16'h0042, 1,16'h0040));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,16'h0044, 1,16'h0040));
    // Back-to-back redirects: the second target wins.
    vecs.push_back(mk(1,1,0,0,16'h0, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0002, 1,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0004, 1,16'h0002));
    vecs.push_back(mk(0,1,0,1,16'h0100, 0,16'h0006, 1,16'h0004));
    vecs.push_back(mk(0,1,0,1,16'h0200, 0,16'h0100, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0200, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0202, 1,16'h0200));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0204, 1,16'h0202));
    // Halt during streaming, then resume without gap or duplicate.
    vecs.push_back(mk(1,1,0,0,16'h0, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0002, 1,16'h0000));
    vecs.push_back(mk(0,1,1,0,16'h0, 0,16'h0004, 1,16'h0002));
    vecs.push_back(mk(0,1,1,0,16'h0, 0,16'h0004, 0,16'h0000));
    vecs.push_back(mk(0,1,1,0,16'h0, 0,16'h0004, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 0,16'h0004, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0004, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0006, 1,16'h0004));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0008, 1,16'h0006));
    // Reset while a response is pending; the stale memory data must not appear afterwards.
    vecs.push_back(mk(1,1,0,0,16'h0, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0002, 1,16'h0000));
    vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h0004, 1,16'h0002));

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) doReset(i);
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
